// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared types and constants for the IFU/LSU bus arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam int XLEN             = 32;
  localparam int ARB_SRC_WIDTH    = 1;
  localparam int MAX_OUTST_DEF    = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [ARB_SRC_WIDTH-1:0] arb_src_t;

  localparam arb_src_t ARB_SRC_IFU = 1'b0;
  localparam arb_src_t ARB_SRC_LSU = 1'b1;

  typedef enum logic [0:0] {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_order_fifo.sv
// ============================================================================
// mem_arbiter_order_fifo : in-order source-id FIFO for outstanding bus requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_order_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF
) (
  input  logic     clk,
  input  logic     rst_b,
  input  logic     push,
  input  arb_src_t push_src,
  input  logic     pop,
  output arb_src_t head,
  output logic     full,
  output logic     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  arb_src_t      mem [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_src;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares the core memory bus between IFU fetches and LSU accesses
// Optional IFU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTST    = MAX_OUTST_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ifu_req,
  input  logic [XLEN-1:0]   ifu_addr,
  output logic              ifu_ready,
  output logic              ifu_rvalid,
  output logic [XLEN-1:0]   ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_write,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [XLEN/8-1:0] lsu_strb,
  output logic              lsu_ready,
  output logic              lsu_rvalid,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              bus_req,
  output logic              bus_write,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_strb,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  if (MAX_OUTST < 1 || MAX_OUTST > 8 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("mem_arbiter: MAX_OUTST must be 1..8 and STARVE_LIMIT >= 1");
  end

  arb_state_t state, state_nxt;
  arb_src_t   sel, sel_q, head;
  logic       full, empty, accept, rsp_ok, starve_force;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  logic [SCW-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                               starve_cnt <= '0;
    else if (!ifu_req || ifu_ready)           starve_cnt <= '0;
    else if (starve_cnt != SCW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end

  assign starve_force = ifu_req && (starve_cnt >= SCW'(STARVE_LIMIT));
`else
  assign starve_force = 1'b0;
`endif

  assign bus_req = (ifu_req | lsu_req) & ~full;
  assign accept  = bus_req & bus_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ARB_FREE;
      sel_q <= ARB_SRC_IFU;
    end else begin
      state <= state_nxt;
      sel_q <= sel;
    end
  end

  // While locked the registered winner is held so an offered request never changes.
  always_comb begin
    state_nxt = state;
    sel       = sel_q;
    if (state == ARB_FREE) begin
      if (starve_force)  sel = ARB_SRC_IFU;
      else if (lsu_req)  sel = ARB_SRC_LSU;
      else               sel = ARB_SRC_IFU;
    end
    if (accept)       state_nxt = ARB_FREE;
    else if (bus_req) state_nxt = ARB_LOCKED;
  end

  assign ifu_ready = accept & (sel == ARB_SRC_IFU);
  assign lsu_ready = accept & (sel == ARB_SRC_LSU);

  assign bus_write = (sel == ARB_SRC_LSU) & lsu_write;
  assign bus_addr  = (sel == ARB_SRC_LSU) ? lsu_addr  : ifu_addr;
  assign bus_wdata = (sel == ARB_SRC_LSU) ? lsu_wdata : '0;
  assign bus_strb  = (sel == ARB_SRC_LSU) ? lsu_strb  : '0;

  mem_arbiter_order_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_order_fifo (
    .clk      (clk),
    .rst_b    (rst_b),
    .push     (accept),
    .push_src (sel),
    .pop      (rsp_ok),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Stray responses with nothing outstanding are dropped.
  assign rsp_ok     = bus_rvalid & ~empty;
  assign lsu_rvalid = rsp_ok & (head == ARB_SRC_LSU);
  assign ifu_rvalid = rsp_ok & (head == ARB_SRC_IFU);
  assign lsu_rdata  = bus_rdata;
  assign ifu_rdata  = bus_rdata;

  a_no_stray_rsp : assert property (@(posedge clk) disable iff (!rst_b)
                                    !(bus_rvalid && empty));

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core memory bus port between instruction fetch (IFU, read-only) and load/store (LSU, read/write, driven by decoded mem_read/mem_write/mem_opcode).
- Grants one request per accepted bus handshake.
- Tracks outstanding requests in order so each bus response is routed back to the requester that issued it.
- Sits between the IFU/LSU stages and the external memory bus interface.

Parameters:
- MAX_OUTST, 2, maximum accepted-but-unanswered bus requests (1..8).
- STARVE_LIMIT, 4, cycles an IFU request may lose arbitration before it is forced (only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  core clock
- rst_b  in  1  asynchronous active-low reset
- ifu_req  in  1  fetch request valid
- ifu_addr  in  XLEN  fetch address
- ifu_ready  out  1  fetch request accepted this cycle
- ifu_rvalid  out  1  fetch response valid
- ifu_rdata  out  XLEN  fetch response data
- lsu_req  in  1  data request valid
- lsu_write  in  1  1=store, 0=load
- lsu_addr  in  XLEN  data address
- lsu_wdata  in  XLEN  store data
- lsu_strb  in  XLEN/8  byte strobes
- lsu_ready  out  1  data request accepted this cycle
- lsu_rvalid  out  1  data response valid (load data or store ack)
- lsu_rdata  out  XLEN  load data
- bus_req  out  1  bus request valid
- bus_write, bus_addr, bus_wdata, bus_strb  out  1/XLEN/XLEN/XLEN/8  muxed request fields
- bus_ready  in  1  bus accepts request
- bus_rvalid  in  1  bus response valid (one per request, in order, reads and writes)
- bus_rdata  in  XLEN  bus response data

Behaviour:
- Reset: order FIFO empty, count=0, lock=0, starve_cnt=0; all ready/rvalid/bus_req outputs 0.
- Accept = bus_req & bus_ready. The granted requester's ready equals accept (combinational, 0-cycle).
- bus_req = (ifu_req | lsu_req) & (count < MAX_OUTST). When full, bus_req=0 and both readies are 0.
- Arbitration: LSU has fixed priority over IFU. While lock=0 the winner is chosen combinationally.
- Lock:
  - If bus_req=1 & bus_ready=0, lock<=1 and sel is registered; the selected requester stays granted until accepted. A higher-priority arrival does not preempt a pending unaccepted request.
  - Lock clears on accept.
  - Requesters must hold req and fields stable until ready.
- Order FIFO, depth MAX_OUTST, 1-bit source id:
  - Push source on accept; pop on bus_rvalid.
  - Push and pop in the same cycle leave count unchanged.
  - Route: head=LSU -> lsu_rvalid=bus_rvalid, lsu_rdata=bus_rdata; else the IFU equivalents. The unselected rvalid is 0. Rdata is passed through unconditionally.
- Response latency: 0 cycles (combinational pass-through). Request latency: 0 cycles from req to bus_req.
- bus_rvalid with count=0: ignored, FIFO unchanged; simulation assertion fires.
- Reset mid-operation: outstanding entries discarded; responses arriving after reset deassertion with count=0 follow the rule above.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - starve_cnt increments each cycle ifu_req=1 and IFU is not accepted.
  - starve_cnt clears on IFU accept or when ifu_req=0.
  - When starve_cnt >= STARVE_LIMIT and lock=0, IFU wins over LSU for the next grant.
- Undefined: strict LSU priority; the counter is not instantiated.

Decomposition:
- core.svh: ARB_SRC_IFU=1'b0, ARB_SRC_LSU=1'b1, ARB_SRC_WIDTH.
- config.svh: default MAX_OUTST, and ARB_STARVE_GUARD_EN left undefined.
- Sub-module arb_order_fifo: synchronous FIFO with push/pop/full/empty/head and parameterized depth. Simultaneous push/pop on empty (push-first, head valid next cycle) is not required, since a response cannot precede its accept.

Test Plan:
- IFU only, ifu_addr=0x100, bus_ready=1 -> ifu_ready=1 same cycle; bus_rvalid=1 with data 0x00000013 two cycles later -> ifu_rvalid=1, ifu_rdata=0x13, lsu_rvalid=0.
- Both request same cycle, bus_ready=1 -> LSU granted (bus_addr=lsu_addr); IFU granted the next cycle; responses D1,D2 route LSU then IFU.
- IFU pending with bus_ready=0 for 3 cycles, then lsu_req rises -> bus_addr stays ifu_addr until accept, and only then the LSU is granted.
- MAX_OUTST=2: two accepts with no responses -> bus_req=0, readies=0; one bus_rvalid -> next request accepted the following cycle. Same-cycle accept and response keep count=2.
- LSU store: lsu_write=1, strb=4'b0011 -> bus_write=1, bus_strb=0011; ack bus_rvalid -> lsu_rvalid=1.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: lsu_req held high continuously plus ifu_req -> IFU granted on the 5th cycle; without the macro, IFU is never granted while lsu_req=1.
